saturating_subtract_pipe: RTL and testbench

//  Two-stage pipelined saturating subtractor, R = A - B, for the execute datapath.

---
 rtl/sat_arith_pkg.sv | 35 +++
 rtl/sat_sub_clamp.sv | 59 +++++
 rtl/saturating_subtract_pipe.sv | 135 +++++++++++++
 tb/tb_saturating_subtract_pipe.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sat_arith_pkg.sv
// Shared definitions for the saturating subtract datapath.
//   - sat_mode_e  : operand interpretation (unsigned / signed two's complement)
//   - sat_flags_t : saturation flag bundle {po, no, uf}
//   - sat_p_max / sat_n_max / sat_zero : clamp values for a given width,
//     returned at SAT_MAX_WIDTH bits; callers cast to their own width.
package sat_arith_pkg;

    localparam int SAT_MAX_WIDTH = 64;

    typedef enum logic {
        SAT_MODE_UNSIGNED = 1'b0,
        SAT_MODE_SIGNED   = 1'b1
    } sat_mode_e;

    typedef struct packed {
        logic po;   // signed positive overflow, clamped to P_MAX
        logic no;   // signed negative overflow, clamped to N_MAX
        logic uf;   // unsigned borrow, clamped to zero
    } sat_flags_t;

    // Largest positive signed value: {0, 1..1}
    function automatic logic [SAT_MAX_WIDTH-1:0] sat_p_max(input int unsigned width);
        return (SAT_MAX_WIDTH'(1) << (width - 1)) - SAT_MAX_WIDTH'(1);
    endfunction

    // Most negative signed value: {1, 0..0}
    function automatic logic [SAT_MAX_WIDTH-1:0] sat_n_max(input int unsigned width);
        return SAT_MAX_WIDTH'(1) << (width - 1);
    endfunction

    function automatic logic [SAT_MAX_WIDTH-1:0] sat_zero(input int unsigned width);
        return (width == 0) ? '0 : '0;
    endfunction

endpackage

// File: rtl/sat_sub_clamp.sv
// Combinational clamp stage for a saturating subtract R = A - B.
// Works only from the wrapped difference and the operand sign bits, so the
// upstream stage does not need to carry the full operands.
// Ports:
//   diff    in   WIDTH  wrapped difference A - B
//   a_msb   in   1      sign bit of A
//   b_msb   in   1      sign bit of B
//   mode    in   1      sat_mode_e, signed or unsigned interpretation
//   result  out  WIDTH  clamped difference
//   flags   out  3      {po, no, uf}; only the active mode's flags can be set
module sat_sub_clamp
    import sat_arith_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] diff,
    input  logic             a_msb,
    input  logic             b_msb,
    input  sat_mode_e        mode,
    output logic [WIDTH-1:0] result,
    output sat_flags_t       flags
);

    localparam logic [WIDTH-1:0] P_MAX = WIDTH'(sat_p_max(WIDTH));
    localparam logic [WIDTH-1:0] N_MAX = WIDTH'(sat_n_max(WIDTH));
    localparam logic [WIDTH-1:0] ZERO  = WIDTH'(sat_zero(WIDTH));

    logic d_msb;
    logic po;
    logic no;
    logic uf;

    assign d_msb = diff[WIDTH-1];

    // Signed overflow: operands of opposite sign and the result sign disagrees with A.
    assign po = (mode == SAT_MODE_SIGNED) &  !a_msb &  b_msb &  d_msb;
    assign no = (mode == SAT_MODE_SIGNED) &   a_msb & !b_msb & !d_msb;

    // Borrow out of the MSB column: either 0-1 there, or equal MSBs with a
    // borrow coming in, and that incoming borrow is exactly what D[MSB] shows.
    assign uf = (mode == SAT_MODE_UNSIGNED) &
                ((!a_msb & b_msb) | (!(a_msb ^ b_msb) & d_msb));

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        result = diff;
        if (po) begin
            result = P_MAX;
        end else if (no) begin
            result = N_MAX;
        end else if (uf) begin
            result = ZERO;
        end
    end

    assign flags = '{po: po, no: no, uf: uf};

endmodule

// File: rtl/saturating_subtract_pipe.sv
// Two-stage pipelined saturating subtractor R = A - B with valid/ready on
// both sides, sticky saturation status and a saturating event counter.
//   S1: wrapped difference, operand sign bits and mode.
//   S2: clamped result and saturation flags (drives the out_* payload).
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready          operand handshake
//   in_signed, in_a, in_b      mode (1 = signed), minuend, subtrahend
//   out_valid/out_ready        result handshake
//   out_result                 clamped difference
//   out_po, out_no, out_uf     saturation flags of the presented result
//   clear_sticky               clears sticky_sat and sat_count
//   sticky_sat                 set by any saturated result that transfers out
//   sat_count                  saturated transfers seen, holds at all-ones
module saturating_subtract_pipe
    import sat_arith_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_signed,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_result,
    output logic                 out_po,
    output logic                 out_no,
    output logic                 out_uf,
    input  logic                 clear_sticky,
    output logic                 sticky_sat,
    output logic [CNT_WIDTH-1:0] sat_count
);

    // Stage 1 registers
    logic             s1_valid;
    logic [WIDTH-1:0] s1_diff;
    logic             s1_a_msb;
    logic             s1_b_msb;
    sat_mode_e        s1_mode;

    // Stage 2 registers
    logic             s2_valid;
    logic [WIDTH-1:0] s2_result;
    sat_flags_t       s2_flags;

    // Clamp stage outputs
    logic [WIDTH-1:0] clamp_result;
    sat_flags_t       clamp_flags;

    logic s1_adv;
    logic s2_adv;
    logic sat_evt;

    // A stage may load when it is empty or its contents move on this cycle.
    assign s2_adv   = !s2_valid | out_ready;
    assign s1_adv   = !s1_valid | s2_adv;
    assign in_ready = s1_adv;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and stage order in the source is irrelevant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_diff  <= '0;
            s1_a_msb <= 1'b0;
            s1_b_msb <= 1'b0;
            s1_mode  <= SAT_MODE_UNSIGNED;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_diff  <= in_a - in_b;
                s1_a_msb <= in_a[WIDTH-1];
                s1_b_msb <= in_b[WIDTH-1];
                s1_mode  <= sat_mode_e'(in_signed);
            end
        end
    end

    sat_sub_clamp #(
        .WIDTH (WIDTH)
    ) u_clamp (
        .diff   (s1_diff),
        .a_msb  (s1_a_msb),
        .b_msb  (s1_b_msb),
        .mode   (s1_mode),
        .result (clamp_result),
        .flags  (clamp_flags)
    );

    // NOTE: the payload registers are reset as well as the valids, because the
    // result and flag outputs must read zero after reset, not stale data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_flags  <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_result <= clamp_result;
                s2_flags  <= clamp_flags;
            end
        end
    end

    assign out_valid  = s2_valid;
    assign out_result = s2_result;
    assign out_po     = s2_flags.po;
    assign out_no     = s2_flags.no;
    assign out_uf     = s2_flags.uf;

    assign sat_evt = out_valid & out_ready & (|s2_flags);

    // A saturation event in the same cycle as clear_sticky wins: the clear
    // drops history and the new event is recorded on top.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_sat <= 1'b0;
            sat_count  <= '0;
        end else begin
            sticky_sat <= sat_evt | (sticky_sat & !clear_sticky);
            if (clear_sticky) begin
                sat_count <= CNT_WIDTH'(sat_evt);
            end else if (sat_evt && (sat_count != '1)) begin
                sat_count <= sat_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_saturating_subtract_pipe.sv
// Self-checking bench for saturating_subtract_pipe (WIDTH=8, CNT_WIDTH=4).
// Expected results come from an integer-arithmetic reference model; they are
// queued when an operand transfer is seen and compared by a monitor when the
// DUT transfers a result out. Sticky/counter status is modelled alongside.
module tb_saturating_subtract_pipe;

    localparam int W  = 8;
    localparam int CW = 4;

    typedef struct packed {
        logic [W-1:0] r;
        logic         po;
        logic         no;
        logic         uf;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_signed = 1'b0;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_result;
    logic          out_po;
    logic          out_no;
    logic          out_uf;
    logic          clear_sticky = 1'b0;
    logic          sticky_sat;
    logic [CW-1:0] sat_count;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    // status model
    logic  m_sticky = 1'b0;
    int    m_count  = 0;
    logic  have_hold = 1'b0;
    exp_t  hold_val;
    logic  rand_done;

    saturating_subtract_pipe #(
        .WIDTH     (W),
        .CNT_WIDTH (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_signed    (in_signed),
        .in_a         (in_a),
        .in_b         (in_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_po       (out_po),
        .out_no       (out_no),
        .out_uf       (out_uf),
        .clear_sticky (clear_sticky),
        .sticky_sat   (sticky_sat),
        .sat_count    (sat_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_expired(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Reference: plain integer subtraction, then clamp to the representable range.
    function automatic exp_t ref_sub(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        int   d;
        exp_t e;
        e = '0;
        if (s) begin
            d = int'($signed(a)) - int'($signed(b));
            if (d > 127) begin
                e.r = 8'h7F; e.po = 1'b1;
            end else if (d < -128) begin
                e.r = 8'h80; e.no = 1'b1;
            end else begin
                e.r = W'(d);
            end
        end else begin
            d = int'(a) - int'(b);
            if (d < 0) begin
                e.r = '0; e.uf = 1'b1;
            end else begin
                e.r = W'(d);
            end
        end
        return e;
    endfunction

    // Monitor/scoreboard: inputs change only just after posedge, so the
    // negedge sees the handshake values that the next posedge will act on.
    always @(negedge clk) begin
        logic evt;
        exp_t got;
        exp_t exp;
        evt = 1'b0;
        if (!rst_n) begin
            exp_q.delete();
            m_sticky  = 1'b0;
            m_count   = 0;
            have_hold = 1'b0;
        end else begin
            check("sticky_sat", 32'(sticky_sat), 32'(m_sticky));
            check("sat_count", 32'(sat_count), 32'(m_count));
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_sub(in_signed, in_a, in_b));
            end
            got = '{r: out_result, po: out_po, no: out_no, uf: out_uf};
            if (out_valid) begin
                if (have_hold) begin
                    check("payload_hold", 32'(got), 32'(hold_val));
                end
                if (out_ready) begin
                    have_hold = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got 0x%0h with empty queue at %0t", got, $time);
                    end else begin
                        exp = exp_q.pop_front();
                        check("result_flags", 32'(got), 32'(exp));
                        evt = exp.po | exp.no | exp.uf;
                    end
                end else begin
                    hold_val  = got;
                    have_hold = 1'b1;
                end
            end else begin
                have_hold = 1'b0;
            end
            m_sticky = evt | (m_sticky & !clear_sticky);
            if (clear_sticky) begin
                m_count = evt ? 1 : 0;
            end else if (evt && m_count < 15) begin
                m_count++;
            end
        end
    end

    // Present one operand pair and hold it until accepted; leaves in_valid high.
    task automatic send(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        int waited;
        waited    = 0;
        in_valid  = 1'b1;
        in_signed = s;
        in_a      = a;
        in_b      = b;
        @(negedge clk);
        while (!in_ready) begin
            waited++;
            if (waited > 200) begin
                bound_expired("send_accept");
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int waited;
        waited    = 0;
        idle();
        out_ready = 1'b1;
        while (exp_q.size() != 0 || out_valid) begin
            waited++;
            if (waited > 100) begin
                bound_expired("drain");
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 8'h7F;
            1:       return 8'h80;
            2:       return 8'h00;
            3:       return 8'hFF;
            default: return W'($urandom());
        endcase
    endfunction

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_result", 32'(out_result), 0);
        check("rst_flags", 32'({out_po, out_no, out_uf}), 0);
        check("rst_sticky", 32'(sticky_sat), 0);
        check("rst_count", 32'(sat_count), 0);

        // 1: signed positive overflow, latency and sticky
        out_ready = 1'b1;
        send(1'b1, 8'h7F, 8'hFF);
        idle();
        check("lat_s1_only", 32'(out_valid), 0);
        @(posedge clk); #1;
        check("lat_out_valid", 32'(out_valid), 1);
        check("t1_result", 32'(out_result), 32'h7F);
        check("t1_po", 32'(out_po), 1);
        @(posedge clk); #1;
        check("t1_sticky", 32'(sticky_sat), 1);

        // 2, 3: signed negative overflow, plain signed, unsigned borrow, plain unsigned
        send(1'b1, 8'h80, 8'h01);
        send(1'b1, 8'h05, 8'h03);
        send(1'b0, 8'h03, 8'h05);
        send(1'b0, 8'hFF, 8'h01);
        drain();

        // 4: back-to-back with out_ready low for 3 cycles
        out_ready = 1'b0;
        send(1'b1, 8'h10, 8'h01);
        send(1'b0, 8'h20, 8'h30);
        check("bp_in_ready_low", 32'(in_ready), 0);
        check("bp_out_valid", 32'(out_valid), 1);
        in_a = 8'h40; in_b = 8'h02; in_signed = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            check("bp_in_ready_held", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        send(1'b0, 8'h40, 8'h02);
        send(1'b1, 8'h80, 8'h7F);
        drain();

        // Randomized traffic with random backpressure and clears
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send(1'($urandom()), pick_operand(), pick_operand());
                    if ($urandom_range(0, 3) == 0) begin
                        idle();
                        repeat ($urandom_range(1, 3)) @(posedge clk);
                        #1;
                    end
                end
                idle();
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    out_ready    = ($urandom_range(0, 3) != 0);
                    clear_sticky = ($urandom_range(0, 19) == 0);
                    @(posedge clk); #1;
                end
                clear_sticky = 1'b0;
            end
        join
        drain();

        // 5: counter saturation and clear/event collision
        clear_sticky = 1'b1;
        @(posedge clk); #1;
        clear_sticky = 1'b0;
        check("clr_count", 32'(sat_count), 0);
        check("clr_sticky", 32'(sticky_sat), 0);
        for (int i = 0; i < 16; i++) begin
            send(1'b1, 8'h7F, 8'hFF);
        end
        drain();
        check("count_full", 32'(sat_count), 32'hF);
        send(1'b0, 8'h00, 8'h01);
        drain();
        check("count_holds", 32'(sat_count), 32'hF);
        send(1'b1, 8'h80, 8'h01);
        idle();
        @(posedge clk); #1;
        check("clr_evt_valid", 32'(out_valid), 1);
        clear_sticky = 1'b1;
        @(posedge clk); #1;
        clear_sticky = 1'b0;
        check("clr_evt_sticky", 32'(sticky_sat), 1);
        check("clr_evt_count", 32'(sat_count), 1);

        // 6: reset with both stages full
        out_ready = 1'b0;
        send(1'b1, 8'h7F, 8'hFF);
        send(1'b1, 8'h7F, 8'hFF);
        idle();
        check("pre_rst_full", 32'(in_ready), 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst2_out_valid", 32'(out_valid), 0);
        check("rst2_in_ready", 32'(in_ready), 1);
        check("rst2_count", 32'(sat_count), 0);
        check("rst2_sticky", 32'(sticky_sat), 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst2_no_replay", 32'(out_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
